// File: rtl/xain_pkg.sv
// Shared types and constants for the Xain'd Sleena audio path.
package xain_pkg;

    typedef enum logic [1:0] {
        MIX_NONE,
        MIX_25,
        MIX_50,
        MIX_MONO
    } audio_mix_e;

    localparam int AUDIO_W = 16;

endpackage

// File: rtl/xain_audio_mixer_if.sv
// Valid/ready stereo sample stream from the mixer FIFO head to the audio output stage.
interface xain_audio_mixer_if import xain_pkg::*; #(
    parameter int W = AUDIO_W
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_l;
    logic [W-1:0] out_r;

    modport master (output out_valid, output out_l, output out_r, input out_ready);
    modport slave  (input out_valid, input out_l, input out_r, output out_ready);
endinterface

// File: rtl/xain_audio_fifo.sv
// Generic synchronous FIFO: register-array storage, wrap-bit pointers, combinational head read.
module xain_audio_fifo import xain_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int DW    = 2 * AUDIO_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_do_rd;
    logic          w_do_wr;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;

    // A pop frees a slot in the same cycle, so a full FIFO still takes the write.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/xain_audio_mixer.sv
// Stereo crossfeed/mute stage: capture on core strobe, mix, then buffer in a small FIFO.
module xain_audio_mixer import xain_pkg::*; #(
    parameter int FIFO_DEPTH = 8,
    parameter int W          = AUDIO_W,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample,
    input  logic signed [W-1:0] snd1,
    input  logic signed [W-1:0] snd2,
    input  logic [1:0]          mix,
    input  logic                mute,
    xain_audio_mixer_if.master  out,
    output logic [LW-1:0]       level,
    output logic                overflow
);
    localparam int XW = W + 3;

    logic                r_s1_valid;
    logic signed [W-1:0] r_a;
    logic signed [W-1:0] r_b;
    audio_mix_e          r_mix;
    logic                r_mute;

    logic                r_s2_valid;
    logic [W-1:0]        r_l;
    logic [W-1:0]        r_r;

    logic signed [XW-1:0] w_a;
    logic signed [XW-1:0] w_b;
    logic signed [XW-1:0] w_sum_l;
    logic signed [XW-1:0] w_sum_r;
    logic [W-1:0]         w_l;
    logic [W-1:0]         w_r;

    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [2*W-1:0]       w_rd_data;

    // Stage 1: mix/mute are latched with the samples so mode changes apply per capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= sample;
        end
        if (sample) begin
            r_a    <= snd1;
            r_b    <= snd2;
            r_mix  <= audio_mix_e'(mix);
            r_mute <= mute;
        end
    end

    assign w_a = {{3{r_a[W-1]}}, r_a};
    assign w_b = {{3{r_b[W-1]}}, r_b};

    // Weighted averages: three guard bits hold 8x a full-scale sample, so truncation never wraps.
    always_comb begin
        w_sum_l = w_a;
        w_sum_r = w_b;
        case (r_mix)
            MIX_25: begin
                w_sum_l = ((w_a <<< 1) + w_a + w_b) >>> 2;
                w_sum_r = (w_a + (w_b <<< 1) + w_b) >>> 2;
            end
            MIX_50: begin
                w_sum_l = ((w_a <<< 2) + w_a + (w_b <<< 1) + w_b) >>> 3;
                w_sum_r = ((w_a <<< 1) + w_a + (w_b <<< 2) + w_b) >>> 3;
            end
            MIX_MONO: begin
                w_sum_l = (w_a + w_b) >>> 1;
                w_sum_r = (w_a + w_b) >>> 1;
            end
            default: ;
        endcase
    end

    assign w_l = r_mute ? '0 : w_sum_l[W-1:0];
    assign w_r = r_mute ? '0 : w_sum_r[W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
        end
        r_l <= w_l;
        r_r <= w_r;
    end

    assign w_pop = out.out_valid && out.out_ready;

    xain_audio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (2 * W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (r_s2_valid),
        .wr_data ({r_l, r_r}),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .empty   (w_empty),
        .full    (w_full),
        .level   (level)
    );

    assign out.out_valid = !w_empty;
    assign out.out_l     = w_empty ? '0 : w_rd_data[2*W-1:W];
    assign out.out_r     = w_empty ? '0 : w_rd_data[W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (r_s2_valid && w_full && !w_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xain_audio_mixer.sv
// Self-checking bench for xain_audio_mixer: directed corner cases plus random traffic vs. a queue model.
module tb_xain_audio_mixer;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample;
    logic signed [W-1:0] snd1;
    logic signed [W-1:0] snd2;
    logic [1:0]          mix;
    logic                mute;
    logic [3:0]          level;
    logic                overflow;

    xain_audio_mixer_if #(.W(W)) bus ();

    xain_audio_mixer #(.FIFO_DEPTH(DEPTH), .W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .sample   (sample),
        .snd1     (snd1),
        .snd2     (snd2),
        .mix      (mix),
        .mute     (mute),
        .out      (bus),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] d;
    } ent_t;

    ent_t        pipe[$];
    logic [31:0] q[$];
    bit          m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int n, input int d);
        int quo;
        quo = n / d;
        if ((n % d != 0) && (n < 0)) quo = quo - 1;
        return quo;
    endfunction

    function automatic logic [31:0] mix_ref(input logic [15:0] a16, input logic [15:0] b16,
                                            input logic [1:0] m, input bit mu);
        int a, b, l, r;
        logic [31:0] res;
        a = int'($signed(a16));
        b = int'($signed(b16));
        case (m)
            2'd1:    begin l = fdiv(3*a + b, 4);   r = fdiv(a + 3*b, 4);   end
            2'd2:    begin l = fdiv(5*a + 3*b, 8); r = fdiv(3*a + 5*b, 8); end
            2'd3:    begin l = fdiv(a + b, 2);     r = l;                  end
            default: begin l = a;                  r = b;                  end
        endcase
        if (mu) begin
            l = 0;
            r = 0;
        end
        res = {l[15:0], r[15:0]};
        return res;
    endfunction

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0;
        e.d = '0;
        q.delete();
        pipe.delete();
        pipe.push_back(e);
        pipe.push_back(e);
        m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid", {31'd0, bus.out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        check("level", {28'd0, level}, q.size());
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (q.size() != 0) begin
            check("out_l", {16'd0, bus.out_l}, {16'd0, q[0][31:16]});
            check("out_r", {16'd0, bus.out_r}, {16'd0, q[0][15:0]});
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic cycle(input bit s, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m, input bit mu, input bit rdy, input bit rst);
        ent_t cand, nxt;
        bit   pop, was_full;
        reset         = rst;
        sample        = s;
        snd1          = a;
        snd2          = b;
        mix           = m;
        mute          = mu;
        bus.out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            pop      = (q.size() != 0) && rdy;
            was_full = (q.size() == DEPTH);
            cand     = pipe.pop_front();
            if (pop) void'(q.pop_front());
            if (cand.v) begin
                if (!was_full || pop) q.push_back(cand.d);
                else m_ovf = 1'b1;
            end
            nxt.v = s;
            nxt.d = mix_ref(a, b, m, mu);
            pipe.push_back(nxt);
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic rnd_strobe(input logic [1:0] m, input bit rdy);
        cycle(1'b1, 16'($urandom), 16'($urandom), m, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; sample = 1'b0; snd1 = '0; snd2 = '0; mix = 2'd0; mute = 1'b0;
        bus.out_ready = 1'b0;

        cycle(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("reset_out_l", {16'd0, bus.out_l}, 32'd0);
        check("reset_out_r", {16'd0, bus.out_r}, 32'd0);

        // Passthrough: visible three clocks after the strobe.
        cycle(1'b1, 16'h1234, 16'hFEDC, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("pt_not_yet", {31'd0, bus.out_valid}, 32'd0);
        idle(1'b0);
        check("pt_l", {16'd0, bus.out_l}, 32'h1234);
        check("pt_r", {16'd0, bus.out_r}, 32'hFEDC);
        idle(1'b1);

        // Mono rounds toward minus infinity: (100 - 301) / 2 -> -101.
        cycle(1'b1, 16'd100, 16'hFED3, 2'd3, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("mono_l", {16'd0, bus.out_l}, 32'hFF9B);
        check("mono_r", {16'd0, bus.out_r}, 32'hFF9B);
        idle(1'b1);

        // Full-scale opposite samples through mix 1 and mix 2 (floor of 16383.25/-16384.25, 8191.375/-8192.375).
        cycle(1'b1, 16'h7FFF, 16'h8000, 2'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h7FFF, 16'h8000, 2'd2, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("mix1_l", {16'd0, bus.out_l}, 32'h3FFF);
        check("mix1_r", {16'd0, bus.out_r}, 32'hBFFF);
        idle(1'b1);
        check("mix2_l", {16'd0, bus.out_l}, 32'h1FFF);
        check("mix2_r", {16'd0, bus.out_r}, 32'hDFFF);
        idle(1'b1);

        // Fill to exactly DEPTH, then land a push on a pop while full.
        for (int i = 0; i < DEPTH; i++) rnd_strobe(2'(i), 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("fill_level", {28'd0, level}, DEPTH);
        check("fill_no_ovf", {31'd0, overflow}, 32'd0);
        rnd_strobe(2'd1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        check("pushpop_level", {28'd0, level}, DEPTH);
        check("pushpop_no_ovf", {31'd0, overflow}, 32'd0);

        // Two more strobes with no room overflow and leave the head in place.
        rnd_strobe(2'd0, 1'b0);
        rnd_strobe(2'd0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("ovf_level", {28'd0, level}, DEPTH);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        check("drained", {31'd0, bus.out_valid}, 32'd0);

        // Reset one cycle after a strobe, with a strobe coinciding with reset.
        rnd_strobe(2'd2, 1'b0);
        rnd_strobe(2'd3, 1'b0);
        cycle(1'b1, 16'h5555, 16'hAAAA, 2'd0, 1'b0, 1'b0, 1'b1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);

        // Muted strobes still push zeros.
        cycle(1'b1, 16'h7123, 16'h8456, 2'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0F0F, 16'hF0F0, 2'd2, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check("mute_l", {16'd0, bus.out_l}, 32'd0);
        check("mute_r", {16'd0, bus.out_r}, 32'd0);
        check("mute_level", {28'd0, level}, 32'd1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 6), 16'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
